addr_table_loader: RTL and testbench
====================================

# addr_table_loader

- Writer side of the random-address table consumed by `address_mem`.
- Generates 8192 pseudo-random, mutually distinct 18-bit `{row[8:0], col[8:0]}` coordinates for a 512x512 map and writes them into the table through a ready/valid write port.
- Sits between the SOM controller, which issues `start`, and the table RAM.
- Replaces file-based table preloading with a seedable, on-chip sequence.

## Interface
Parameters:
- `ENTRIES`, 8192: number of table words written per run.
- `ADDR_W`, 13: table address width; must satisfy 2^ADDR_W >= ENTRIES.
- `SEED`, 18'h1ACE5: fallback LFSR seed, used when `seed_in` is zero; must be nonzero.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin a run; honoured only in IDLE.
- `seed_in`, input, 18: LFSR seed, sampled on the cycle `start` is accepted.
- `wr_en`, output, 1: write request; valid qualifier for `wr_addr` and `wr_data`.
- `wr_addr`, output, ADDR_W: table index being written.
- `wr_data`, output, 18: coordinate word; [17:9]=row, [8:0]=col.
- `wr_ready`, input, 1: table accepts the word when high together with `wr_en`.
- `busy`, output, 1: high while in WRITE.
- `done`, output, 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states are IDLE, WRITE and DONE. Reset forces IDLE.
- IDLE: `start`=1 latches the seed into `lfsr`. If `seed_in`==0 the latched value is SEED, otherwise `seed_in`. Also `cnt`<=0, then next state is WRITE.
- WRITE: `wr_en`=1, `wr_addr`=`cnt`, `wr_data`=`lfsr`.
- A transfer occurs on a cycle where `wr_en` and `wr_ready` are both high. On a transfer, `lfsr` advances and `cnt` increments.
- If a transfer occurs with `cnt`==ENTRIES-1, next state is DONE.
- While `wr_ready`=0, `wr_en`, `wr_addr` and `wr_data` hold unchanged.
- DONE: `done`=1 for exactly one cycle, then next state is IDLE.
- LFSR is an 18-bit Fibonacci register with polynomial x^18+x^11+1. Next value = {lfsr[16:0], lfsr[17]^lfsr[10]}.
- The LFSR is maximal length (period 262143 > ENTRIES), so all words within a run are distinct. Coordinate (0,0) is never produced.
- `start` asserted in WRITE or DONE is ignored; it is not queued.
- Counter width is ADDR_W. `cnt` never wraps within a run, because the run terminates at ENTRIES-1.
- Reset asserted mid-run aborts immediately:
  - The table is left partially written.
  - No `done` pulse is produced.
  - A new `start` is required after reset.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, state=IDLE, `lfsr`=SEED, `cnt`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `wr_ready` or `start` to any output.
- `start` sampled at edge N gives `wr_en`/`busy` high from cycle N+1, carrying word 0.
- With `wr_ready` held high:
  - One word is transferred per cycle over cycles N+1..N+ENTRIES.
  - `done` is high at cycle N+ENTRIES+1.
  - `busy` is low in that cycle.
  - The FSM is back in IDLE at N+ENTRIES+2.
- Each cycle of `wr_ready`=0 in WRITE adds exactly one cycle of latency.

## Configuration
- Macro: `ADDR_LOADER_CHECKSUM_EN`.
- Defined:
  - Adds output `checksum` [31:0], holding the unsigned sum of `wr_data` over all accepted transfers.
  - `checksum` is cleared to 0 when `start` is accepted and by reset.
  - It is stable from the `done` cycle until the next accepted `start`.
  - It never overflows: 8192 x 262143 < 2^31.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

## Test plan
- Reset, then `seed_in`=18'h00001 with `start`, `wr_ready`=1:
  - Words 0..10 = 1<<k, i.e. word 10 = 18'h00400.
  - Word 11 = 18'h00801.
  - `wr_addr` runs 0..11 on consecutive cycles.
- `seed_in`=0 with `start` -> word 0 = 18'h1ACE5.
- Full run, `wr_ready`=1:
  - 8192 transfers, no duplicate `wr_data`, no word equal to 0.
  - `done` exactly once at cycle start+8193.
  - With `ADDR_LOADER_CHECKSUM_EN` defined, `checksum` equals the bench's model sum.
- `wr_ready` toggled pseudo-randomly (about 50% duty):
  - Outputs hold while `wr_ready` is low.
  - The accepted sequence is identical to the `wr_ready`=1 run.
  - `done` is delayed by exactly the number of stall cycles.
- `start` pulsed mid-run at word 100 -> no restart, sequence continues, a single `done`.
- `rst_n` low at word 500 -> all outputs return to their reset values asynchronously, no `done`; a fresh `start` restarts from word 0 and `wr_addr` 0.

Source files
------------

// File: rtl/addr_table_loader.sv
// Seedable LFSR writer for the random-address coordinate table.
// Optional checksum output: define ADDR_LOADER_CHECKSUM_EN.
module addr_table_loader #(
  parameter int          ENTRIES = 8192,
  parameter int          ADDR_W  = 13,
  parameter logic [17:0] SEED    = 18'h1ACE5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [17:0]       seed_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [17:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
`ifdef ADDR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  state_t            state;
  logic [17:0]       lfsr;
  logic [17:0]       lfsr_nxt;
  logic [17:0]       seed_eff;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  // x^18 + x^11 + 1, maximal length
  assign lfsr_nxt = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;
  assign cnt_nxt  = cnt + ADDR_W'(1);
  assign wr_addr  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= SEED;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef ADDR_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lfsr    <= seed_eff;
            cnt     <= '0;
            wr_en   <= 1'b1;
            wr_data <= seed_eff;
            busy    <= 1'b1;
            state   <= WRITE;
`ifdef ADDR_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        WRITE: begin
          if (wr_ready) begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt_nxt;
`ifdef ADDR_LOADER_CHECKSUM_EN
            checksum <= checksum + 32'(lfsr);
`endif
            if (cnt == LAST) begin
              wr_en   <= 1'b0;
              wr_data <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              wr_data <= lfsr_nxt;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_table_loader.sv
// Randomized self-checking bench for addr_table_loader.
// Checksum checks are built when ADDR_LOADER_CHECKSUM_EN is defined.
module tb_addr_table_loader;

  localparam int ENTRIES = 8192;
  localparam int ADDR_W  = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [17:0]       seed_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [17:0]       wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;
`ifdef ADDR_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_w [ENTRIES];
  bit          seen [logic [17:0]];

  always #5 clk = ~clk;

  addr_table_loader #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W),
    .SEED   (18'h1ACE5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .seed_in (seed_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .busy    (busy),
    .done    (done)
`ifdef ADDR_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  function automatic logic [17:0] step(input logic [17:0] x);
    return {x[16:0], x[17] ^ x[10]};
  endfunction

  task automatic apply_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b0;
    seed_in  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [17:0] s);
    seed_in = s;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset en=%b addr=%0d data=%h busy=%b done=%b (want all 0)",
               wr_en, wr_addr, wr_data, busy, done);
    end
`ifdef ADDR_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd0) begin
      failures++;
      $display("FAIL reset_checksum got=%0d want=0", checksum);
    end
`endif
  endtask

  task automatic test_seed_one();
    logic [17:0] e;
    apply_reset();
    wr_ready = 1'b1;
    start_run(18'h00001);
    for (int k = 0; k < 12; k++) begin
      e = (k <= 10) ? (18'd1 << k) : 18'h00801;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== k[ADDR_W-1:0] || wr_data !== e) begin
        failures++;
        $display("FAIL seed_one k=%0d en=%b addr=%0d data=%h want addr=%0d data=%h",
                 k, wr_en, wr_addr, wr_data, k, e);
      end
      @(posedge clk);
      #1;
    end
    apply_reset();
  endtask

  task automatic test_zero_seed();
    wr_ready = 1'b1;
    start_run(18'h00000);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 18'h1ACE5) begin
      failures++;
      $display("FAIL zero_seed en=%b data=%h want en=1 data=1ace5", wr_en, wr_data);
    end
    apply_reset();
  endtask

  // One run checked against the model: optional stall rate,
  // start poke at word poke_at, async reset at word rst_at.
  task automatic do_run(input logic [17:0] seed, input int stall_pct,
                        input int poke_at, input int rst_at);
    int          k      = 0;
    int          stalls = 0;
    int          cyc    = 1;
    bit          fin    = 0;
    bit          prev_stall = 0;
    logic [31:0] sum    = '0;
    logic [17:0] pd     = '0;
    logic [ADDR_W-1:0] pa = '0;

    exp_w[0] = (seed == 18'd0) ? 18'h1ACE5 : seed;
    for (int i = 1; i < ENTRIES; i++) exp_w[i] = step(exp_w[i-1]);
    seen.delete();

    start_run(seed);
    while (!fin && cyc < 3 * ENTRIES + 20) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL async_reset en=%b addr=%0d data=%h busy=%b done=%b (want all 0)",
                   wr_en, wr_addr, wr_data, busy, done);
        end
`ifdef ADDR_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'd0) begin
          failures++;
          $display("FAIL async_reset_checksum got=%0d want=0", checksum);
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (4) begin
          @(posedge clk);
          #1;
          checks++;
          if (done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle done=%b en=%b busy=%b want 0 0 0",
                     done, wr_en, busy);
          end
        end
        fin = 1;
        break;
      end
      if (k < ENTRIES) begin
        checks++;
        if (wr_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL ctl k=%0d en=%b busy=%b done=%b want 1 1 0",
                   k, wr_en, busy, done);
        end
        checks++;
        if (wr_addr !== k[ADDR_W-1:0] || wr_data !== exp_w[k]) begin
          failures++;
          $display("FAIL word k=%0d addr=%0d data=%h want addr=%0d data=%h",
                   k, wr_addr, wr_data, k, exp_w[k]);
        end
        if (prev_stall) begin
          checks++;
          if (wr_addr !== pa || wr_data !== pd) begin
            failures++;
            $display("FAIL hold k=%0d addr=%0d data=%h want addr=%0d data=%h",
                     k, wr_addr, wr_data, pa, pd);
          end
        end
        pa = wr_addr;
        pd = wr_data;
        if (k == poke_at) begin
          start   = 1'b1;
          seed_in = 18'($urandom);
        end
        wr_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
        prev_stall = !wr_ready;
        if (wr_ready) begin
          checks++;
          if (seen.exists(wr_data) || wr_data == 18'd0) begin
            failures++;
            $display("FAIL unique k=%0d data=%h repeated or zero", k, wr_data);
          end
          seen[wr_data] = 1'b1;
          sum += 32'(wr_data);
          k++;
        end else begin
          stalls++;
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
          failures++;
          $display("FAIL done_pulse done=%b busy=%b en=%b want 1 0 0",
                   done, busy, wr_en);
        end
        checks++;
        if (cyc != ENTRIES + 1 + stalls) begin
          failures++;
          $display("FAIL done_cycle got=%0d want=%0d", cyc, ENTRIES + 1 + stalls);
        end
`ifdef ADDR_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
          failures++;
          $display("FAIL checksum got=%0d want=%0d", checksum, sum);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
          failures++;
          $display("FAIL after_done done=%b busy=%b en=%b want 0 0 0",
                   done, busy, wr_en);
        end
`ifdef ADDR_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
          failures++;
          $display("FAIL checksum_hold got=%0d want=%0d", checksum, sum);
        end
`endif
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk);
        #1 start = 1'b0;
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL timeout words=%0d got no done within %0d cycles", k, cyc);
    end
  endtask

  task automatic test_full(input logic [17:0] s);
    do_run(s, 0, -1, -1);
  endtask

  task automatic test_stall(input logic [17:0] s);
    do_run(s, 50, -1, -1);
  endtask

  task automatic test_mid_start(input logic [17:0] s);
    do_run(s, 0, 100, -1);
  endtask

  task automatic test_reset_mid(input logic [17:0] s);
    do_run(s, 0, -1, 500);
    do_run(s, 0, -1, -1);
  endtask

  initial begin
    logic [17:0] s;
    rst_n    = 1'b0;
    start    = 1'b0;
    seed_in  = '0;
    wr_ready = 1'b0;
    s = 18'($urandom);
    test_reset();
    test_seed_one();
    test_zero_seed();
    test_full(s);
    test_stall(s);
    test_mid_start(18'($urandom));
    test_reset_mid(18'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
